mem_port_arbiter: RTL and testbench

//  Shares one single-ported, fixed-latency memory between the fetch stage (IF) and the memory stage (DM).

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between
// the fetch stage (IF) and the memory stage (DM). Each access is sampled in
// IDLE, strobed to memory for one cycle in ISSUE, waits out the read
// latency in WAIT and returns a one-cycle ready pulse in RESP.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [DATA_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall_f,
  output logic                  stall_m
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            r_state;
  logic                  r_grant_if;
  logic                  r_we;
  logic [CNT_W-1:0]      r_cnt;
  logic [STV_W-1:0]      r_starve;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;

  logic w_any_req;
  logic w_pick_if;
  logic w_sample;
  logic w_capture;

  // DM normally wins; IF is forced once it has been passed over STARVE_LIMIT times.
  assign w_any_req = if_req | dm_req;
  assign w_pick_if = if_req & (~dm_req | (r_starve == STV_MAX));
  assign w_sample  = (r_state == S_IDLE) & w_any_req;
  // Reads always pass through WAIT; with MEM_LATENCY==1 that is a single
  // cycle at count 0, which is the cycle mem_rdata is valid.
  assign w_capture = (r_state == S_WAIT) & (r_cnt == '0);

  // Sequencing FSM, grant register, latency counter and starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_grant_if <= 1'b0;
      r_we       <= 1'b0;
      r_cnt      <= '0;
      r_starve   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_ISSUE;
            r_grant_if <= w_pick_if;
            r_we       <= ~w_pick_if & dm_we;
            if (w_pick_if) begin
              r_starve <= '0;
            end else if (if_req && (r_starve != STV_MAX)) begin
              r_starve <= r_starve + STV_W'(1);
            end
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            r_state <= S_RESP;
          end else begin
            r_cnt   <= CNT_LOAD;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory request registers are loaded at the IDLE sample; read data lands
  // only in the granted port's register so the other port's data is untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      if (w_sample) begin
        r_mem_addr  <= w_pick_if ? if_addr : dm_addr;
        r_mem_wdata <= w_pick_if ? '0 : dm_wdata;
      end
      if (w_capture) begin
        if (r_grant_if) begin
          r_if_rdata <= mem_rdata;
        end else begin
          r_dm_rdata <= mem_rdata;
        end
      end
    end
  end

  // Strobes and ready pulses decode straight from the state, so reset
  // removes them in the same cycle it is asserted.
  assign mem_en    = (r_state == S_ISSUE);
  assign mem_we    = r_we & mem_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ready  = (r_state == S_RESP) & r_grant_if;
  assign dm_ready  = (r_state == S_RESP) & ~r_grant_if;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign stall_f   = if_req & ~if_ready;
  assign stall_m   = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timeline model.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SLIM = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_en, mem_we, stall_f, stall_m;

  logic        reset_1;
  logic        if_req_1, dm_req_1, dm_we_1;
  logic [31:0] if_addr_1, dm_addr_1, dm_wdata_1, mem_rdata_1;
  logic [31:0] if_rdata_1, dm_rdata_1, mem_addr_1, mem_wdata_1;
  logic        if_ready_1, dm_ready_1, mem_en_1, mem_we_1, stall_f_1, stall_m_1;

  mem_port_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(SLIM)) u_dut_lat1 (
    .clk(clk), .reset(reset_1),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
    .dm_req(dm_req_1), .dm_we(dm_we_1), .dm_addr(dm_addr_1), .dm_wdata(dm_wdata_1),
    .dm_rdata(dm_rdata_1), .dm_ready(dm_ready_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .stall_f(stall_f_1), .stall_m(stall_m_1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Memory environment: contents plus one pending read response.
  logic [31:0] mem_map [logic [31:0]];
  int          resp_cyc = -1;
  logic [31:0] resp_val;

  // Timeline model: one access in flight, described by its sample cycle
  // and the cycle its ready pulse is due.
  bit          m_busy, m_if, m_st;
  int          m_t = -10, m_done = -10, m_starve;
  logic [31:0] m_addr, m_val;
  logic [31:0] e_if_rdata, e_dm_rdata, e_mem_addr, e_mem_wdata;
  bit          e_mem_we;
  bit          prev_if_rdy, prev_dm_rdy;
  int          grants[$];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_map.exists(a)) return mem_map[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%b expected=%b", nm, cyc, got, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_starve = 0; e_mem_we = 0;
    e_if_rdata = '0; e_dm_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
    mem_rdata = (cyc == resp_cyc) ? resp_val : $urandom;
  endtask

  // Called after the inputs of the current cycle are set: compare, let the
  // memory react, then advance the model across the coming clock edge.
  task automatic step();
    bit x_en, x_ir, x_dr;
    #1;
    if (!reset) model_reset();
    x_en = m_busy && (cyc == m_t + 1);
    x_ir = m_busy && m_if && (cyc == m_done);
    x_dr = m_busy && !m_if && (cyc == m_done);
    chk1("mem_en", mem_en, x_en);
    chk1("if_ready", if_ready, x_ir);
    chk1("dm_ready", dm_ready, x_dr);
    chk1("stall_f", stall_f, if_req & ~x_ir);
    chk1("stall_m", stall_m, dm_req & ~x_dr);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("dm_rdata", dm_rdata, e_dm_rdata);
    chk("mem_addr", mem_addr, e_mem_addr);
    if (x_en) begin
      chk1("mem_we", mem_we, e_mem_we);
      if (e_mem_we) chk("mem_wdata", mem_wdata, e_mem_wdata);
    end
    if (if_ready === 1'b1) grants.push_back(1);
    if (dm_ready === 1'b1) grants.push_back(2);
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem_map[mem_addr] = mem_wdata;
      else begin
        resp_val = rd(mem_addr);
        resp_cyc = cyc + LAT;
      end
    end
    prev_if_rdy = x_ir;
    prev_dm_rdy = x_dr;
    if (reset) begin
      if (m_busy) begin
        if (!m_st && (cyc == m_t + 1 + LAT)) begin
          if (m_if) e_if_rdata = m_val;
          else e_dm_rdata = m_val;
        end
        if (cyc == m_done) m_busy = 0;
      end else if (if_req || dm_req) begin
        m_if = if_req && (!dm_req || (m_starve == SLIM));
        if (m_if) m_starve = 0;
        else if (if_req && (m_starve < SLIM)) m_starve++;
        m_st        = !m_if && dm_we;
        m_addr      = m_if ? if_addr : dm_addr;
        m_val       = rd(m_addr);
        e_mem_addr  = m_addr;
        e_mem_we    = m_st;
        e_mem_wdata = m_if ? 32'h0 : dm_wdata;
        m_t         = cyc;
        m_done      = cyc + (m_st ? 2 : LAT + 2);
        m_busy      = 1;
      end
    end
  endtask

  initial begin
    int exp_g[5];
    reset = 0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    reset_1 = 0; if_req_1 = 0; dm_req_1 = 0; dm_we_1 = 0;
    if_addr_1 = '0; dm_addr_1 = '0; dm_wdata_1 = '0; mem_rdata_1 = '0;
    mem_map[32'h00400004] = 32'h20080005;
    mem_map[32'h10010008] = 32'h0000002A;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state; stalls follow the requests while in reset.
    next_cycle(); if_req = 1; dm_req = 1; step();
    chk1("rst_stall_f", stall_f, 1'b1);
    chk1("rst_stall_m", stall_m, 1'b1);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // Lone fetch.
    next_cycle(); reset = 1; dm_req = 0; if_addr = 32'h00400004; step();
    for (int i = 1; i <= 5; i++) begin
      next_cycle(); if_addr = $urandom; if (i == 5) if_req = 0; step();
      if (i == 1) begin
        chk1("t1_mem_en", mem_en, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h00400004);
      end
      if (i == 3) chk1("t1_stall_f_T3", stall_f, 1'b1);
      if (i == 4) begin
        chk1("t1_if_ready", if_ready, 1'b1);
        chk("t1_if_rdata", if_rdata, 32'h20080005);
        chk1("t1_stall_f_T4", stall_f, 1'b0);
      end
    end

    // Store.
    next_cycle(); dm_req = 1; dm_we = 1; dm_addr = 32'h10010000; dm_wdata = 32'hDEADBEEF; step();
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom_range(0, 1));
      if (i == 3) dm_req = 0;
      step();
      if (i == 1) begin
        chk1("t2_mem_en", mem_en, 1'b1);
        chk1("t2_mem_we", mem_we, 1'b1);
        chk("t2_mem_addr", mem_addr, 32'h10010000);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
      end
      if (i == 2) begin
        chk1("t2_dm_ready", dm_ready, 1'b1);
        chk("t2_if_rdata", if_rdata, 32'h20080005);
      end
    end

    // Simultaneous requests: DM first, then IF.
    next_cycle(); dm_req = 1; dm_we = 0; dm_addr = 32'h10010008;
    if_req = 1; if_addr = 32'h00400008; step();
    for (int i = 1; i <= 10; i++) begin
      next_cycle(); if (i == 5) dm_req = 0; if (i == 10) if_req = 0; step();
      if (i == 4) begin
        chk1("t3_dm_ready", dm_ready, 1'b1);
        chk("t3_dm_rdata", dm_rdata, 32'h0000002A);
      end
      if (i == 6) chk("t3_if_mem_addr", mem_addr, 32'h00400008);
      if (i == 9) chk1("t3_if_ready", if_ready, 1'b1);
    end

    // Continuous loads from both ports: starvation forces one IF grant.
    grants.delete();
    next_cycle(); dm_req = 1; dm_we = 0; if_req = 1; step();
    for (int i = 0; i < 28; i++) begin
      next_cycle(); dm_addr = $urandom; if_addr = $urandom; step();
    end
    next_cycle(); dm_req = 0; if_req = 0; step();
    for (int i = 0; i < 6; i++) begin next_cycle(); step(); end
    exp_g = '{2, 2, 2, 1, 2};
    for (int j = 0; j < 5; j++)
      chk($sformatf("t4_grant%0d", j), 32'((grants.size() > j) ? grants[j] : 0), 32'(exp_g[j]));

    // Reset during WAIT of a load, then a fresh fetch.
    next_cycle(); dm_req = 1; dm_we = 0; dm_addr = 32'h10010008; step();
    next_cycle(); step();
    next_cycle(); reset = 0; step();
    chk1("t5_mem_en", mem_en, 1'b0);
    chk1("t5_dm_ready", dm_ready, 1'b0);
    chk("t5_dm_rdata", dm_rdata, 32'h0);
    next_cycle(); dm_req = 0; if_req = 1; if_addr = 32'h00400004; step();
    next_cycle(); reset = 1; step();
    for (int i = 1; i <= 5; i++) begin
      next_cycle(); if (i == 5) if_req = 0; step();
      chk1("t5_no_dm_ready", dm_ready, 1'b0);
      if (i == 1) chk1("t5_mem_en_fresh", mem_en, 1'b1);
      if (i == 4) begin
        chk1("t5_if_ready", if_ready, 1'b1);
        chk("t5_if_rdata", if_rdata, 32'h20080005);
      end
    end

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      next_cycle();
      if (!reset) reset = 1;
      else if ($urandom_range(0, 299) == 0) reset = 0;
      if (!if_req || prev_if_rdy) if_req = 1'($urandom_range(0, 1));
      if (!dm_req || prev_dm_rdy) dm_req = 1'($urandom_range(0, 1));
      dm_we    = 1'($urandom_range(0, 1));
      dm_addr  = 32'h10010000 + 32'(4 * $urandom_range(0, 7));
      if_addr  = 32'h10010000 + 32'(4 * $urandom_range(0, 7));
      dm_wdata = $urandom;
      step();
    end

    // MEM_LATENCY=1 load on the second instance.
    next_cycle(); reset = 1; if_req = 0; dm_req = 0; reset_1 = 1; step();
    for (int i = 0; i < 6; i++) begin next_cycle(); step(); end
    next_cycle(); dm_req_1 = 1; dm_we_1 = 0; dm_addr_1 = 32'h10010020; mem_rdata_1 = $urandom; step();
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      mem_rdata_1 = (i <= 3) ? 32'h12345678 : $urandom;
      if (i == 4) dm_req_1 = 0;
      step();
      if (i == 1) begin
        chk1("t6_mem_en", mem_en_1, 1'b1);
        chk("t6_mem_addr", mem_addr_1, 32'h10010020);
      end
      if (i == 2) chk1("t6_no_early_ready", dm_ready_1, 1'b0);
      if (i == 3) begin
        chk1("t6_dm_ready", dm_ready_1, 1'b1);
        chk("t6_dm_rdata", dm_rdata_1, 32'h12345678);
      end
      if (i == 4) begin
        chk1("t6_ready_once", dm_ready_1, 1'b0);
        chk("t6_dm_rdata_held", dm_rdata_1, 32'h12345678);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
